// File: rtl/idu_pkg.sv
// Shared decode types for the barrel-pipeline instruction decode unit:
// opcode classes, RV32I major opcodes, immediate formats and thread state.
package idu_pkg;

    typedef enum logic [3:0] {
        OP_NOP    = 4'd0,
        OP_LUI    = 4'd1,
        OP_AUIPC  = 4'd2,
        OP_JAL    = 4'd3,
        OP_JALR   = 4'd4,
        OP_BRANCH = 4'd5,
        OP_LOAD   = 4'd6,
        OP_STORE  = 4'd7,
        OP_IMM    = 4'd8,
        OP_REG    = 4'd9,
        OP_SYSTEM = 4'd10
    } op_class_t;

    // instr[6:2] values; instr[1:0] must be 2'b11 for any legal RV32I word
    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    typedef enum logic [2:0] {
        IMM_R = 3'd0,
        IMM_I = 3'd1,
        IMM_S = 3'd2,
        IMM_B = 3'd3,
        IMM_U = 3'd4,
        IMM_J = 3'd5
    } imm_fmt_t;

    typedef enum logic {
        TS_RUN  = 1'b0,
        TS_HALT = 1'b1
    } thread_state_t;

endpackage

// File: rtl/idu_imm_gen.sv
// Combinational RV32I immediate generator: selects and sign-extends the
// immediate bits of instr[31:7] according to the decoded format.
module idu_imm_gen
    import idu_pkg::*;
(
    input  logic [31:7] i_instr,
    input  imm_fmt_t    i_fmt,
    output logic [31:0] o_imm
);

    // Format-dependent immediate assembly; R-type and unknown formats yield zero
    always_comb begin
        o_imm = 32'd0;
        case (i_fmt)
            IMM_I:   o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
            IMM_S:   o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_B:   o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                              i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_U:   o_imm = {i_instr[31:12], 12'd0};
            IMM_J:   o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                              i_instr[20], i_instr[30:21], 1'b0};
            IMM_R:   o_imm = 32'd0;
            default: o_imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/idu.sv
// Instruction decode unit for the 4-thread barrel pipeline: RV32I field decode,
// warm-up gating after reset and per-thread RUN/HALT tracking, one cycle latency.
module idu
    import idu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ADDR_LEN    = 15,
    parameter int NUM_THREADS = 4,
    parameter int FETCH_LAT   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [XLEN-1:0]                instr,
    input  logic [$clog2(NUM_THREADS)-1:0] tid_in,
    input  logic [ADDR_LEN-3:0]            pc_in,
    input  logic [NUM_THREADS-1:0]         resume,
    output logic                           dec_valid,
    output logic [$clog2(NUM_THREADS)-1:0] dec_tid,
    output logic [ADDR_LEN-3:0]            dec_pc,
    output op_class_t                      dec_op,
    output logic [4:0]                     dec_rd,
    output logic [4:0]                     dec_rs1,
    output logic [4:0]                     dec_rs2,
    output logic [2:0]                     dec_funct3,
    output logic                           dec_funct7b5,
    output logic [XLEN-1:0]                dec_imm,
    output logic                           dec_illegal,
    output logic [NUM_THREADS-1:0]         thread_halted
);

    localparam int TID_W = $clog2(NUM_THREADS);
    localparam int CNT_W = $clog2(FETCH_LAT + 1);

    logic [CNT_W-1:0] r_warm;
    thread_state_t    r_state     [NUM_THREADS];
    thread_state_t    w_state_nxt [NUM_THREADS];

    logic [4:0]  w_opc;
    op_class_t   w_op;
    imm_fmt_t    w_fmt;
    logic        w_known;
    logic        w_illegal;
    logic        w_ecall;
    logic        w_valid;
    logic        w_halt_evt;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [31:0] w_imm;

    idu_imm_gen u_imm_gen (
        .i_instr (instr[31:7]),
        .i_fmt   (w_fmt),
        .o_imm   (w_imm)
    );

    // Opcode class, immediate format and register-field masking
    always_comb begin
        w_opc   = instr[6:2];
        w_op    = OP_NOP;
        w_fmt   = IMM_R;
        w_known = 1'b1;
        w_rd    = instr[11:7];
        w_rs1   = instr[19:15];
        w_rs2   = instr[24:20];
        case (w_opc)
            OPC_LUI:      begin w_op = OP_LUI;    w_fmt = IMM_U; w_rs1 = 5'd0; w_rs2 = 5'd0; end
            OPC_AUIPC:    begin w_op = OP_AUIPC;  w_fmt = IMM_U; w_rs1 = 5'd0; w_rs2 = 5'd0; end
            OPC_JAL:      begin w_op = OP_JAL;    w_fmt = IMM_J; w_rs1 = 5'd0; w_rs2 = 5'd0; end
            OPC_JALR:     begin w_op = OP_JALR;   w_fmt = IMM_I; end
            OPC_BRANCH:   begin w_op = OP_BRANCH; w_fmt = IMM_B; w_rd  = 5'd0; end
            OPC_LOAD:     begin w_op = OP_LOAD;   w_fmt = IMM_I; end
            OPC_STORE:    begin w_op = OP_STORE;  w_fmt = IMM_S; w_rd  = 5'd0; end
            OPC_OP_IMM:   begin w_op = OP_IMM;    w_fmt = IMM_I; end
            OPC_OP:       begin w_op = OP_REG;    w_fmt = IMM_R; end
            OPC_SYSTEM:   begin w_op = OP_SYSTEM; w_fmt = IMM_I; end
            OPC_MISC_MEM: begin w_op = OP_NOP;    w_fmt = IMM_I; end
            default:      begin w_known = 1'b0;   w_fmt = IMM_R; end
        endcase
        w_illegal = !w_known || (instr[1:0] != 2'b11);
        if (w_illegal) begin
            w_op = OP_NOP;
        end else begin
            w_op = w_op;
        end
    end

    // Slot validity and trap detection (ECALL/EBREAK share funct3 == 0)
    always_comb begin
        w_ecall    = (w_opc == OPC_SYSTEM) && (instr[14:12] == 3'd0);
        w_valid    = (r_warm == {CNT_W{1'b0}}) && (r_state[tid_in] == TS_RUN);
        w_halt_evt = w_valid && (w_illegal || w_ecall);
    end

    // Per-thread next state: a trap on this slot beats a same-cycle resume
    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            w_state_nxt[t] = r_state[t];
            if (w_halt_evt && (tid_in == TID_W'(t))) begin
                w_state_nxt[t] = TS_HALT;
            end else if ((r_state[t] == TS_HALT) && resume[t]) begin
                w_state_nxt[t] = TS_RUN;
            end else begin
                w_state_nxt[t] = r_state[t];
            end
        end
    end

    // Warm-up counter, thread FSM array and registered decode outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_warm        <= CNT_W'(FETCH_LAT);
            for (int t = 0; t < NUM_THREADS; t++) begin
                r_state[t] <= TS_RUN;
            end
            thread_halted <= {NUM_THREADS{1'b0}};
            dec_valid     <= 1'b0;
            dec_tid       <= {TID_W{1'b0}};
            dec_pc        <= {(ADDR_LEN-2){1'b0}};
            dec_op        <= OP_NOP;
            dec_rd        <= 5'd0;
            dec_rs1       <= 5'd0;
            dec_rs2       <= 5'd0;
            dec_funct3    <= 3'd0;
            dec_funct7b5  <= 1'b0;
            dec_imm       <= {XLEN{1'b0}};
            dec_illegal   <= 1'b0;
        end else begin
            if (r_warm != {CNT_W{1'b0}}) begin
                r_warm <= r_warm - CNT_W'(1);
            end else begin
                r_warm <= r_warm;
            end
            for (int t = 0; t < NUM_THREADS; t++) begin
                r_state[t]       <= w_state_nxt[t];
                thread_halted[t] <= (w_state_nxt[t] == TS_HALT);
            end
            dec_valid     <= w_valid;
            dec_tid       <= tid_in;
            dec_pc        <= pc_in;
            dec_op        <= w_op;
            dec_rd        <= w_rd;
            dec_rs1       <= w_rs1;
            dec_rs2       <= w_rs2;
            dec_funct3    <= instr[14:12];
            dec_funct7b5  <= instr[30];
            dec_imm       <= XLEN'(w_imm);
            dec_illegal   <= w_illegal;
        end
    end

endmodule

// File: tb/tb_idu.sv
// Self-checking bench for idu: hand-derived decode table, directed halt/resume
// and reset sequences, then random traffic against a behavioural model.
module tb_idu;
    import idu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic [1:0]  tid_in;
    logic [12:0] pc_in;
    logic [3:0]  resume;
    logic        dec_valid;
    logic [1:0]  dec_tid;
    logic [12:0] dec_pc;
    op_class_t   dec_op;
    logic [4:0]  dec_rd, dec_rs1, dec_rs2;
    logic [2:0]  dec_funct3;
    logic        dec_funct7b5;
    logic [31:0] dec_imm;
    logic        dec_illegal;
    logic [3:0]  thread_halted;

    int vectors = 0;
    int miscompares = 0;

    idu dut (
        .clk(clk), .rst(rst), .instr(instr), .tid_in(tid_in), .pc_in(pc_in),
        .resume(resume), .dec_valid(dec_valid), .dec_tid(dec_tid), .dec_pc(dec_pc),
        .dec_op(dec_op), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_funct3(dec_funct3), .dec_funct7b5(dec_funct7b5), .dec_imm(dec_imm),
        .dec_illegal(dec_illegal), .thread_halted(thread_halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [1:0]  tid;
        logic [12:0] pc;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] imm;
        logic        ill;
        logic [3:0]  halted;
    } obs_t;

    typedef struct {
        logic [31:0] w;
        op_class_t   op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] imm;
    } vec_t;

    // model state: cycles of warm-up left and which threads are parked
    int m_warm;
    bit m_halted [4];

    function automatic obs_t ref_decode(logic [31:0] w);
        obs_t o;
        logic [6:0] key;
        o     = '0;
        key   = {w[6:2], 2'b11};
        o.rd  = w[11:7];
        o.rs1 = w[19:15];
        o.rs2 = w[24:20];
        o.f3  = w[14:12];
        o.f7  = w[30];
        case (key)
            7'h37: begin o.op = OP_LUI;    o.imm = {w[31:12], 12'h000}; o.rs1 = 5'd0; o.rs2 = 5'd0; end
            7'h17: begin o.op = OP_AUIPC;  o.imm = {w[31:12], 12'h000}; o.rs1 = 5'd0; o.rs2 = 5'd0; end
            7'h6F: begin o.op = OP_JAL;    o.imm = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
                         o.rs1 = 5'd0; o.rs2 = 5'd0; end
            7'h67: begin o.op = OP_JALR;   o.imm = $signed(w[31:20]); end
            7'h63: begin o.op = OP_BRANCH; o.imm = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0}); o.rd = 5'd0; end
            7'h03: begin o.op = OP_LOAD;   o.imm = $signed(w[31:20]); end
            7'h23: begin o.op = OP_STORE;  o.imm = $signed({w[31:25], w[11:7]}); o.rd = 5'd0; end
            7'h13: begin o.op = OP_IMM;    o.imm = $signed(w[31:20]); end
            7'h33: begin o.op = OP_REG;    o.imm = 32'd0; end
            7'h73: begin o.op = OP_SYSTEM; o.imm = $signed(w[31:20]); end
            7'h0F: begin o.op = OP_NOP;    o.imm = $signed(w[31:20]); end
            default: begin o.op = OP_NOP;  o.imm = 32'd0; o.ill = 1'b1; end
        endcase
        if (w[1:0] != 2'b11) o.ill = 1'b1;
        if (o.ill) o.op = OP_NOP;
        return o;
    endfunction

    function automatic obs_t predict(logic [31:0] w, logic [1:0] t, logic [12:0] p,
                                     logic [3:0] res, logic rv);
        obs_t o;
        bit   trap;
        if (!rv) begin
            m_warm = 2;
            foreach (m_halted[k]) m_halted[k] = 1'b0;
            return '0;
        end
        o       = ref_decode(w);
        o.tid   = t;
        o.pc    = p;
        o.valid = (m_warm == 0) && !m_halted[t];
        trap    = o.valid && (o.ill || (w[6:0] == 7'h73 && w[14:12] == 3'd0));
        for (int k = 0; k < 4; k++) begin
            if (k == int'(t) && trap) m_halted[k] = 1'b1;
            else if (res[k])          m_halted[k] = 1'b0;
        end
        if (m_warm > 0) m_warm--;
        for (int k = 0; k < 4; k++) o.halted[k] = m_halted[k];
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.valid = dec_valid;   o.tid = dec_tid;     o.pc = dec_pc;
        o.op = dec_op;         o.rd = dec_rd;       o.rs1 = dec_rs1;
        o.rs2 = dec_rs2;       o.f3 = dec_funct3;   o.f7 = dec_funct7b5;
        o.imm = dec_imm;       o.ill = dec_illegal; o.halted = thread_halted;
        return o;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // one clock: apply inputs, advance model, compare full output bundle
    task automatic drive(input string nm, input logic [31:0] w, input logic [1:0] t,
                         input logic [12:0] p, input logic [3:0] res, input logic rv);
        obs_t e, a;
        rst = rv; instr = w; tid_in = t; pc_in = p; resume = res;
        e = predict(w, t, p, res, rv);
        @(posedge clk);
        #1;
        a = dut_obs();
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (v tid pc op rd rs1 rs2 f3 f7 imm ill halted)", nm, a, e);
        end
    endtask

    localparam logic [31:0] ADDI = 32'h00500093;
    vec_t tbl [12];

    initial begin
        tbl[0]  = '{32'h00500093, OP_IMM,    5'd1, 5'd0, 5'd5,  3'd0, 1'b0, 32'h00000005};
        tbl[1]  = '{32'hFFF00113, OP_IMM,    5'd2, 5'd0, 5'd31, 3'd0, 1'b1, 32'hFFFFFFFF};
        tbl[2]  = '{32'hFE000EE3, OP_BRANCH, 5'd0, 5'd0, 5'd0,  3'd0, 1'b1, 32'hFFFFFFFC};
        tbl[3]  = '{32'hFE000FE3, OP_BRANCH, 5'd0, 5'd0, 5'd0,  3'd0, 1'b1, 32'hFFFFFFFE};
        tbl[4]  = '{32'h123450B7, OP_LUI,    5'd1, 5'd0, 5'd0,  3'd5, 1'b0, 32'h12345000};
        tbl[5]  = '{32'h00112223, OP_STORE,  5'd0, 5'd2, 5'd1,  3'd2, 1'b0, 32'h00000004};
        tbl[6]  = '{32'h0080006F, OP_JAL,    5'd0, 5'd0, 5'd0,  3'd0, 1'b0, 32'h00000008};
        tbl[7]  = '{32'h402081B3, OP_REG,    5'd3, 5'd1, 5'd2,  3'd0, 1'b1, 32'h00000000};
        tbl[8]  = '{32'h0000000F, OP_NOP,    5'd0, 5'd0, 5'd0,  3'd0, 1'b0, 32'h00000000};
        tbl[9]  = '{32'hFFC12083, OP_LOAD,   5'd1, 5'd2, 5'd28, 3'd2, 1'b1, 32'hFFFFFFFC};
        tbl[10] = '{32'hFFFFF117, OP_AUIPC,  5'd2, 5'd0, 5'd0,  3'd7, 1'b1, 32'hFFFFF000};
        tbl[11] = '{32'h000080E7, OP_JALR,   5'd1, 5'd1, 5'd0,  3'd0, 1'b0, 32'h00000000};

        m_warm = 2;
        foreach (m_halted[k]) m_halted[k] = 1'b0;

        // reset state and warm-up: invalid, invalid, then valid on the 3rd cycle
        drive("reset0", ADDI, 2'd0, 13'd0, 4'd0, 1'b0);
        drive("reset1", ADDI, 2'd1, 13'd0, 4'd0, 1'b0);
        chk("reset_outputs", {dec_valid, dec_imm, dec_op, thread_halted}, 64'd0);
        drive("warm1", ADDI, 2'd0, 13'd1, 4'd0, 1'b1);
        chk("warm1_valid", dec_valid, 64'd0);
        drive("warm2", ADDI, 2'd1, 13'd2, 4'd0, 1'b1);
        chk("warm2_valid", dec_valid, 64'd0);
        drive("warm3", ADDI, 2'd2, 13'd3, 4'd0, 1'b1);
        chk("warm3_valid", dec_valid, 64'd1);

        // decode table against hand-derived fields
        for (int i = 0; i < 12; i++) begin
            drive($sformatf("tbl%0d", i), tbl[i].w, 2'((i + 1) % 4), 13'h10 + 13'(i), 4'd0, 1'b1);
            chk($sformatf("tbl%0d_fields", i),
                {dec_valid, dec_illegal, dec_op, dec_rd, dec_rs1, dec_rs2, dec_funct3, dec_funct7b5, dec_imm},
                {1'b1, 1'b0, tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].f3, tbl[i].f7, tbl[i].imm});
        end
        chk("tbl0_tid_pc", {dec_tid, dec_pc}, {2'd0, 13'h1B});

        // illegal word parks thread 2 until resume[2]
        drive("ill_t2", 32'h00000000, 2'd2, 13'd0, 4'd0, 1'b1);
        chk("ill_t2_flags", {dec_illegal, dec_valid, thread_halted}, {1'b1, 1'b1, 4'b0100});
        drive("ill_t3", ADDI, 2'd3, 13'd1, 4'd0, 1'b1);
        chk("ill_t3_valid", dec_valid, 64'd1);
        drive("ill_t0", ADDI, 2'd0, 13'd2, 4'd0, 1'b1);
        drive("ill_t1", ADDI, 2'd1, 13'd3, 4'd0, 1'b1);
        drive("ill_t2b", ADDI, 2'd2, 13'd4, 4'd0, 1'b1);
        chk("halted_t2_valid", dec_valid, 64'd0);
        drive("res_t2", ADDI, 2'd3, 13'd5, 4'b0100, 1'b1);
        chk("res_t2_state", thread_halted, 64'd0);
        drive("res_t0", ADDI, 2'd0, 13'd6, 4'd0, 1'b1);
        drive("res_t1", ADDI, 2'd1, 13'd7, 4'd0, 1'b1);
        drive("res_t2b", ADDI, 2'd2, 13'd8, 4'd0, 1'b1);
        chk("resumed_t2_valid", dec_valid, 64'd1);

        // ebreak with a same-cycle resume: halt wins
        drive("ebreak_t3", 32'h00100073, 2'd3, 13'd9, 4'b1000, 1'b1);
        chk("ebreak_t3_flags", {dec_valid, dec_op, thread_halted}, {1'b1, OP_SYSTEM, 4'b1000});
        drive("eb_res", ADDI, 2'd0, 13'd10, 4'b1000, 1'b1);
        chk("eb_res_state", thread_halted, 64'd0);
        drive("eb_t1", ADDI, 2'd1, 13'd11, 4'd0, 1'b1);
        drive("eb_t2", ADDI, 2'd2, 13'd12, 4'd0, 1'b1);
        drive("eb_t3", ADDI, 2'd3, 13'd13, 4'd0, 1'b1);
        chk("eb_t3_valid", dec_valid, 64'd1);

        // reset mid-operation with threads 1 and 2 halted
        drive("pre_t0", ADDI, 2'd0, 13'd14, 4'd0, 1'b1);
        drive("halt_t1", 32'h00000073, 2'd1, 13'd15, 4'd0, 1'b1);
        drive("halt_t2", 32'hFFFFFFFF, 2'd2, 13'd16, 4'd0, 1'b1);
        chk("pre_rst_halted", thread_halted, 64'b0110);
        drive("midrst", tbl[1].w, 2'd3, 13'd17, 4'd0, 1'b0);
        chk("midrst_outputs", {dec_valid, dec_imm, dec_rd, dec_tid, dec_pc, thread_halted}, 64'd0);
        drive("rw1", ADDI, 2'd0, 13'd18, 4'd0, 1'b1);
        chk("rw1_valid", dec_valid, 64'd0);
        drive("rw2", ADDI, 2'd1, 13'd19, 4'd0, 1'b1);
        chk("rw2_valid", dec_valid, 64'd0);
        drive("rw3", ADDI, 2'd2, 13'd20, 4'd0, 1'b1);
        chk("rw3_valid", dec_valid, 64'd1);

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [31:0] w;
            logic [3:0]  res;
            logic        rv;
            case ($urandom_range(0, 5))
                0:       w = $urandom();
                1:       w = ($urandom_range(0, 1) != 0) ? 32'h00000073 : 32'h00100073;
                2:       w = {$urandom(), 2'b11} & 32'hFFFFFFFF;
                default: w = tbl[$urandom_range(0, 11)].w ^ ({$urandom(), 7'h00} & 32'hFFFFFF80);
            endcase
            res = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            rv  = ($urandom_range(0, 99) != 0);
            drive("rand", w, 2'(n), 13'($urandom()), res, rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
